// File: rtl/calc_pkg.sv
// Shared types and sizing constants for the calc_core arithmetic unit.
package calc_pkg;

   localparam int WIDTH = 10;
   localparam int ACC_W = 2 * WIDTH;
   localparam int REM_W = WIDTH + 1;
   localparam logic [3:0] ITER_LAST = 4'd9;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ADDSUB = 2'b01,
      MUL    = 2'b10,
      DIV    = 2'b11
   } state_t;

endpackage

// File: rtl/calc_seq_unit.sv
// Iterative datapath shared by multiply (shift-add) and divide (restoring).
// The multiplier lives in the low half of acc and shifts out as the product
// shifts in from the top; for divide the low half holds dividend/quotient bits.
module calc_seq_unit
   import calc_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             load_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             step,
   output logic             last,
   output logic [WIDTH-1:0] result,
   output logic             flag
);

   logic [ACC_W-1:0] acc;
   logic [REM_W-1:0] rem;
   logic [WIDTH-1:0] opnd;
   logic [3:0]       cnt;
   logic             mode_div;

   logic [WIDTH:0]   mul_sum;
   logic [ACC_W-1:0] mul_next;
   logic [REM_W:0]   div_shift;
   logic [REM_W+1:0] div_diff;
   logic             div_fit;
   logic [REM_W-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [ACC_W-1:0] acc_next;

   // One iteration's worth of next values; the core also registers these on the final edge.
   always_comb begin
      mul_sum   = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = {rem, acc[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {{(REM_W + 2 - WIDTH){1'b0}}, opnd};
      div_fit   = (div_diff[REM_W+1:REM_W] == 2'b00);
      rem_next  = div_fit ? div_diff[REM_W-1:0] : div_shift[REM_W-1:0];
      quo_next  = {acc[WIDTH-2:0], div_fit};
      acc_next  = mode_div ? {acc[ACC_W-1:WIDTH], quo_next} : mul_next;
      last      = (cnt == ITER_LAST);
      result    = mode_div ? quo_next : mul_next[WIDTH-1:0];
      flag      = mode_div ? (opnd == '0) : (mul_next[ACC_W-1:WIDTH] != '0);
   end

   // Load operands on an accepted start, then advance one iteration per step.
   always_ff @(posedge clock) begin
      if (!reset) begin
         acc      <= '0;
         rem      <= '0;
         opnd     <= '0;
         cnt      <= '0;
         mode_div <= 1'b0;
      end else if (load) begin
         acc      <= {{WIDTH{1'b0}}, (load_div ? a : b)};
         opnd     <= load_div ? b : a;
         rem      <= '0;
         cnt      <= '0;
         mode_div <= load_div;
      end else if (step) begin
         acc <= acc_next;
         rem <= rem_next;
         if (!last) begin
            cnt <= cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/calc_core.sv
// Four-operation unsigned calculator: single-cycle add/sub, ten-cycle mul/div.
module calc_core #(
   parameter int WIDTH = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] ans,
   output logic             done_calc,
   output logic             err,
   output logic             busy
);

   import calc_pkg::*;

   state_t           state;
   state_t           state_next;
   op_t              op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             load;
   logic             step;
   logic             seq_last;
   logic [WIDTH-1:0] seq_result;
   logic             seq_flag;
   logic [WIDTH:0]   add_sum;

   calc_seq_unit u_seq (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .load_div (op_t'(op) == OP_DIV),
      .a        (a),
      .b        (b),
      .step     (step),
      .last     (seq_last),
      .result   (seq_result),
      .flag     (seq_flag)
   );

   assign busy    = (state != IDLE);
   assign add_sum = {1'b0, a_r} + {1'b0, b_r};

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; start is only looked at while idle.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load = 1'b1;
               case (op_t'(op))
                  OP_MUL:  state_next = MUL;
                  OP_DIV:  state_next = DIV;
                  default: state_next = ADDSUB;
               endcase
            end
         end
         ADDSUB: state_next = IDLE;
         default: begin
            step = 1'b1;
            if (seq_last) begin
               state_next = IDLE;
            end
         end
      endcase
   end

   // Capture the request operands so add/sub ignores later input changes.
   always_ff @(posedge clock) begin
      if (!reset) begin
         op_r <= OP_ADD;
         a_r  <= '0;
         b_r  <= '0;
      end else if (load) begin
         op_r <= op_t'(op);
         a_r  <= a;
         b_r  <= b;
      end
   end

   // Result registers: written only on an operation's final edge, otherwise held.
   always_ff @(posedge clock) begin
      if (!reset) begin
         ans       <= '0;
         err       <= 1'b0;
         done_calc <= 1'b0;
      end else begin
         done_calc <= 1'b0;
         if (state == ADDSUB) begin
            done_calc <= 1'b1;
            if (op_r == OP_SUB) begin
               ans <= a_r - b_r;
               err <= (a_r < b_r);
            end else begin
               ans <= add_sum[WIDTH-1:0];
               err <= add_sum[WIDTH];
            end
         end else if ((state == MUL || state == DIV) && seq_last) begin
            done_calc <= 1'b1;
            ans       <= seq_result;
            err       <= seq_flag;
         end
      end
   end

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_calc_core;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] op;
   logic [9:0] a;
   logic [9:0] b;
   logic [9:0] ans;
   logic       done_calc;
   logic       err;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   int d_op  [7] = '{0, 0, 1, 2, 2, 3, 3};
   int d_a   [7] = '{300, 1000, 5, 31, 32, 1000, 5};
   int d_b   [7] = '{200, 100, 9, 33, 32, 7, 0};
   int d_ans [7] = '{500, 76, 1020, 1023, 0, 142, 1023};
   int d_err [7] = '{0, 1, 1, 0, 1, 0, 1};
   int d_lat [7] = '{1, 1, 1, 10, 10, 10, 10};

   calc_core #(.WIDTH(10)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .ans       (ans),
      .done_calc (done_calc),
      .err       (err),
      .busy      (busy)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Reference model straight from the arithmetic definition of each opcode.
   function automatic void model(input logic [1:0] o, input logic [9:0] x, input logic [9:0] y,
                                 output logic [9:0] m_ans, output logic m_err, output int m_lat);
      int unsigned ix;
      int unsigned iy;
      int unsigned r;
      ix = x;
      iy = y;
      case (o)
         2'd0: begin
            r = ix + iy;
            m_ans = 10'(r % 1024);
            m_err = (r > 1023);
            m_lat = 1;
         end
         2'd1: begin
            r = (ix + 1024 - iy) % 1024;
            m_ans = 10'(r);
            m_err = (ix < iy);
            m_lat = 1;
         end
         2'd2: begin
            r = ix * iy;
            m_ans = 10'(r % 1024);
            m_err = (r > 1023);
            m_lat = 10;
         end
         default: begin
            if (iy == 0) begin
               m_ans = 10'h3FF;
               m_err = 1'b1;
            end else begin
               m_ans = 10'(ix / iy);
               m_err = 1'b0;
            end
            m_lat = 10;
         end
      endcase
   endfunction

   // Issue one request (called just after an edge) and wait, bounded, for done_calc.
   task automatic run_op(input logic [1:0] o, input logic [9:0] x, input logic [9:0] y,
                         output int lat, output logic [9:0] r_ans, output logic r_err,
                         output int busy_cnt, output logic busy_done);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clock);
      #1;
      start     = 1'b0;
      op        = 2'($urandom);
      a         = 10'($urandom);
      b         = 10'($urandom);
      lat       = 0;
      busy_cnt  = 0;
      r_ans     = 'x;
      r_err     = 1'bx;
      busy_done = 1'bx;
      for (int k = 1; k <= 20; k++) begin
         if (busy) busy_cnt++;
         @(posedge clock);
         #1;
         if (done_calc) begin
            lat       = k;
            r_ans     = ans;
            r_err     = err;
            busy_done = busy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b1;
      op    = 2'd0;
      a     = 10'd3;
      b     = 10'd4;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (ans !== 10'd0) begin failures++; $display("[TB] FAIL reset_ans: got %0d expected 0", ans); end
      checks++;
      if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %0b expected 0", err); end
      checks++;
      if (done_calc !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %0b expected 0", done_calc); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
      reset = 1'b1;
      start = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || done_calc !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_start_ignored: got busy=%0b done=%0b expected 0/0", busy, done_calc);
      end
   endtask

   task automatic test_directed();
      int         lat;
      int         bcnt;
      logic [9:0] r_ans;
      logic       r_err;
      logic       bdone;
      for (int i = 0; i < 7; i++) begin
         run_op(2'(d_op[i]), 10'(d_a[i]), 10'(d_b[i]), lat, r_ans, r_err, bcnt, bdone);
         checks++;
         if (r_ans !== 10'(d_ans[i])) begin failures++; $display("[TB] FAIL directed_ans[%0d]: got %0d expected %0d", i, r_ans, d_ans[i]); end
         checks++;
         if (r_err !== 1'(d_err[i])) begin failures++; $display("[TB] FAIL directed_err[%0d]: got %0b expected %0d", i, r_err, d_err[i]); end
         checks++;
         if (lat != d_lat[i]) begin failures++; $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, d_lat[i]); end
         checks++;
         if (bcnt != d_lat[i] || bdone !== 1'b0) begin
            failures++;
            $display("[TB] FAIL directed_busy[%0d]: got %0d cycles busy_at_done=%0b expected %0d cycles 0", i, bcnt, bdone, d_lat[i]);
         end
         repeat (2) @(posedge clock);
         #1;
      end
   endtask

   task automatic test_random();
      int         lat;
      int         bcnt;
      int         m_lat;
      logic [9:0] r_ans;
      logic [9:0] m_ans;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] o;
      logic       r_err;
      logic       m_err;
      logic       bdone;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom);
         x = 10'($urandom);
         y = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(0, 3)) : 10'($urandom);
         model(o, x, y, m_ans, m_err, m_lat);
         run_op(o, x, y, lat, r_ans, r_err, bcnt, bdone);
         checks++;
         if (r_ans !== m_ans || r_err !== m_err || lat != m_lat || bcnt != m_lat) begin
            failures++;
            $display("[TB] FAIL random[%0d] op=%0d a=%0d b=%0d: got ans=%0d err=%0b lat=%0d busy=%0d expected ans=%0d err=%0b lat=%0d",
                     i, o, x, y, r_ans, r_err, lat, bcnt, m_ans, m_err, m_lat);
         end
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clock);
            #1;
         end
      end
   endtask

   task automatic test_hold();
      int         lat;
      int         bcnt;
      int         m_lat;
      logic [9:0] r_ans;
      logic [9:0] m_ans;
      logic       r_err;
      logic       m_err;
      logic       bdone;
      model(2'd2, 10'd29, 10'd37, m_ans, m_err, m_lat);
      run_op(2'd2, 10'd29, 10'd37, lat, r_ans, r_err, bcnt, bdone);
      for (int k = 0; k < 5; k++) begin
         @(posedge clock);
         #1;
         checks++;
         if (ans !== m_ans || err !== m_err || done_calc !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold[%0d]: got ans=%0d err=%0b done=%0b busy=%0b expected ans=%0d err=%0b done=0 busy=0",
                     k, ans, err, done_calc, busy, m_ans, m_err);
         end
      end
   endtask

   task automatic test_ignore_start();
      int         done_cnt;
      int         done_k;
      int         m_lat;
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] m_ans;
      logic [9:0] got_ans;
      logic       m_err;
      logic       got_err;
      x = 10'($urandom_range(1, 1023));
      y = 10'($urandom_range(1, 1023));
      model(2'd2, x, y, m_ans, m_err, m_lat);
      start = 1'b1;
      op    = 2'd2;
      a     = x;
      b     = y;
      @(posedge clock);
      #1;
      start    = 1'b0;
      done_cnt = 0;
      done_k   = 0;
      got_ans  = 'x;
      got_err  = 1'bx;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clock);
         #1;
         if (done_calc) begin
            done_cnt++;
            done_k  = k;
            got_ans = ans;
            got_err = err;
         end
         if (k == 2) begin
            start = 1'b1;
            op    = 2'd0;
            a     = 10'($urandom);
            b     = 10'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      checks++;
      if (done_cnt != 1 || done_k != 10) begin
         failures++;
         $display("[TB] FAIL ignore_start_pulses: got %0d pulses last at %0d expected 1 at 10", done_cnt, done_k);
      end
      checks++;
      if (got_ans !== m_ans || got_err !== m_err) begin
         failures++;
         $display("[TB] FAIL ignore_start_result: got ans=%0d err=%0b expected ans=%0d err=%0b", got_ans, got_err, m_ans, m_err);
      end
   endtask

   task automatic test_back_to_back();
      int         lat;
      int         bcnt;
      int         m_lat;
      logic [9:0] r_ans;
      logic [9:0] m_ans;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] seq_ops [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
      logic       r_err;
      logic       m_err;
      logic       bdone;
      for (int i = 0; i < 4; i++) begin
         x = 10'($urandom);
         y = 10'($urandom_range(1, 1023));
         model(seq_ops[i], x, y, m_ans, m_err, m_lat);
         run_op(seq_ops[i], x, y, lat, r_ans, r_err, bcnt, bdone);
         checks++;
         if (r_ans !== m_ans || r_err !== m_err || lat != m_lat) begin
            failures++;
            $display("[TB] FAIL back_to_back[%0d]: got ans=%0d err=%0b lat=%0d expected ans=%0d err=%0b lat=%0d",
                     i, r_ans, r_err, lat, m_ans, m_err, m_lat);
         end
      end
      @(posedge clock);
      #1;
      checks++;
      if (done_calc !== 1'b0) begin failures++; $display("[TB] FAIL back_to_back_pulse_width: got %0b expected 0", done_calc); end
   endtask

   task automatic test_reset_mid();
      int         lat;
      int         bcnt;
      int         done_cnt;
      logic [9:0] r_ans;
      logic       r_err;
      logic       bdone;
      run_op(2'd0, 10'd100, 10'd100, lat, r_ans, r_err, bcnt, bdone);
      start = 1'b1;
      op    = 2'd3;
      a     = 10'd1000;
      b     = 10'd7;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if (ans !== 10'd0 || err !== 1'b0 || done_calc !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mid_outputs: got ans=%0d err=%0b done=%0b busy=%0b expected all 0", ans, err, done_calc, busy);
      end
      reset    = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clock);
         #1;
         if (done_calc) done_cnt++;
      end
      checks++;
      if (done_cnt != 0) begin failures++; $display("[TB] FAIL reset_mid_no_done: got %0d pulses expected 0", done_cnt); end
      run_op(2'd0, 10'd1, 10'd1, lat, r_ans, r_err, bcnt, bdone);
      checks++;
      if (r_ans !== 10'd2 || r_err !== 1'b0 || lat != 1) begin
         failures++;
         $display("[TB] FAIL reset_mid_recover: got ans=%0d err=%0b lat=%0d expected ans=2 err=0 lat=1", r_ans, r_err, lat);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      reset = 1'b0;
      start = 1'b0;
      op    = 2'd0;
      a     = 10'd0;
      b     = 10'd0;
      test_reset();
      test_directed();
      test_hold();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/calc_core.md
CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 SHALL expose parameter WIDTH, default 10, operand/result width; other values are unsupported.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-006 SHALL have port a  input  10  first operand, unsigned.
REQ-007 SHALL have port b  input  10  second operand, unsigned.
REQ-008 SHALL have port ans  output  10  registered result; feeds the downstream output buffer.
REQ-009 SHALL have port done_calc  output  1  one-cycle result-valid pulse.
REQ-010 SHALL have port err  output  1  registered error flag, qualified by done_calc.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ADDSUB, MUL, DIV.
REQ-013 In IDLE with start=1 at edge E0: SHALL latch a, b and op; SHALL go to ADDSUB (op 0x), MUL (10) or DIV (11); SHALL clear the iteration counter.
REQ-014 SHALL ignore start, a, b and op in every state other than IDLE.
REQ-015 ADD: ans = (a+b) mod 1024; err = carry out; written at E0+1.
REQ-016 SUB: ans = (a-b) mod 1024; err = (a<b); written at E0+1.
REQ-017 MUL: SHALL perform 10 shift-add iterations, one per edge, at E0+1..E0+10; ans = low 10 bits of a*b; err = (a*b > 1023).
REQ-018 DIV: SHALL perform 10 restoring-division iterations at E0+1..E0+10; ans = floor(a/b); err = 0.
REQ-019 DIV with b=0: SHALL still take 10 iterations; ans = 10'h3FF; err = 1.
REQ-020 SHALL register done_calc=1, ans and err on the final edge (E0+1 for ADD/SUB, E0+10 for MUL/DIV) and return to IDLE on that edge.
REQ-021 done_calc SHALL be high for exactly one cycle per accepted start and SHALL be 0 in all other cycles.
REQ-022 ans and err SHALL hold their values until the final edge of the next accepted operation.
REQ-023 busy SHALL be 1 from E0+1 through the final edge and 0 in the done_calc cycle.
REQ-024 start=1 in the done_calc cycle SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-025 Internal MUL accumulator SHALL be 20 bits; DIV remainder SHALL be 11 bits; the iteration counter SHALL be 4 bits and stop at 9.

Reset
REQ-026 With reset=0 at a rising edge: state = IDLE, ans = 0, done_calc = 0, err = 0, busy = 0, counter = 0.
REQ-027 Reset mid-operation SHALL abandon the operation with no done_calc pulse; ans SHALL read 0.
REQ-028 start SHALL be ignored on any edge where reset=0.

Structure
REQ-029 Package calc_pkg SHALL hold WIDTH, op_t (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and state_t.
REQ-030 A sub-module calc_seq_unit SHALL hold the shared MUL/DIV shift/accumulate datapath and counter; the FSM and output registers SHALL remain in calc_core.

Verification
REQ-031 ADD a=300, b=200 -> ans=500, err=0, done_calc at E0+1, busy high exactly 1 cycle.
REQ-032 ADD a=1000, b=100 -> ans=76, err=1; SUB a=5, b=9 -> ans=1020, err=1.
REQ-033 MUL 31*33 -> ans=1023, err=0, done_calc at E0+10; MUL 32*32 -> ans=0, err=1.
REQ-034 DIV 1000/7 -> ans=142, err=0; DIV 5/0 -> ans=3FF, err=1, done_calc at E0+10.
REQ-035 Pulse start at E0+3 of a MUL -> ignored, exactly one done_calc; start in the done_calc cycle -> accepted, second done_calc at the correct latency.
REQ-036 reset=0 at E0+5 of a DIV -> all outputs 0 at the next edge, no done_calc; new ADD 1+1 after release -> ans=2.
